// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I funct3
// encodings, dmem size codes and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Stores only exist in signed-less B/H/W form; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational size/sign extension of right-justified dmem read data.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select and extend the loaded field according to the load type
    always_comb begin
        ext = 32'h0000_0000;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'h00_0000, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'h0000, raw[15:0]};
            F3_W:    ext = raw;
            default: ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Single-outstanding RV32I load/store initiator for the byte-addressed dmem.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [1:0]        mem_sz,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [CNT_W-1:0]  ld_cnt,
    output logic [CNT_W-1:0]  st_cnt
);

    lsu_state_e  state_r;
    lsu_state_e  state_s;
    logic        accept_s;
    logic        misalign_s;
    logic        bad_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] ext_s;

    lsu_load_ext u_load_ext (
        .funct3 (funct3_r),
        .raw    (mem_dout),
        .ext    (ext_s)
    );

    // Misalignment detection, only active when trapping is compiled in
    always_comb begin
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (((req_funct3[1:0] == SZ_H) && req_addr[0]) ||
            ((req_funct3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00))) begin
            misalign_s = 1'b1;
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
        bad_s = ~f3_legal(req_we, req_funct3) | misalign_s;
    end

    // Next-state logic
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = bad_s ? ERR : ACCESS;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCESS:  state_s = RESP;
            ERR:     state_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch and dmem drive; enables are flops so reset kills a write at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r      <= 1'b0;
            funct3_r  <= 3'b000;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_sz    <= 2'b00;
            mem_din   <= 32'h0000_0000;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
            end
            if (accept_s && !bad_s) begin
                mem_addr  <= req_addr;
                mem_sz    <= req_funct3[1:0];
                mem_din   <= req_wdata;
                mem_rd_en <= ~req_we;
                mem_wr_en <= req_we;
            end else begin
                mem_rd_en <= 1'b0;
                mem_wr_en <= 1'b0;
            end
        end
    end

    // Handshake flags follow the next state so they change with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_s == IDLE);
            rsp_valid <= (state_s == RESP);
        end
    end

    // Response payload and event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            ld_cnt    <= {CNT_W{1'b0}};
            st_cnt    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ACCESS: begin
                    rsp_rdata <= we_r ? 32'h0000_0000 : ext_s;
                    rsp_err   <= 1'b0;
                    if (we_r) begin
                        st_cnt <= st_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        ld_cnt <= ld_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ERR: begin
                    rsp_rdata <= 32'h0000_0000;
                    rsp_err   <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_err <= 1'b0;
                    end else begin
                        rsp_err <= rsp_err;
                    end
                end
                default: begin
                    rsp_err <= rsp_err;
                end
            endcase
        end
    end

endmodule
